// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: memory read port, decode handshake, next-PC update and fault status.
// master = fetch unit, slave = surrounding core/memory.
interface ifu_fetch_if;
    localparam int unsigned XLEN = 32;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            mem_resp_err;
    logic            IFU_valid;
    logic            IDU_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pc_upd_valid;
    logic [XLEN-1:0] pc_upd;
    logic            fetch_err;
    logic [1:0]      err_cause;

    modport master (
        output mem_req_valid, mem_req_addr, IFU_valid, inst, pc, fetch_err, err_cause,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
               IDU_ready, pc_upd_valid, pc_upd
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, IFU_valid, inst, pc, fetch_err, err_cause,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
               IDU_ready, pc_upd_valid, pc_upd
    );
endinterface

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch unit: one memory read per instruction, presents the
// word to decode over a valid/ready handshake, then waits for the next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic          clk,
    input logic          rst,
    ifu_fetch_if.master  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_MEM      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_REQ,
        S_RESP,
        S_SEND,
        S_WAITPC,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic             ifu_valid_q, ifu_valid_d;
    logic             req_valid_q, req_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic [1:0]       err_cause_q, err_cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;

    logic             cnt_at_limit;

    assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT));

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        ifu_valid_d  = ifu_valid_q;
        req_valid_d  = req_valid_q;
        fetch_err_d  = fetch_err_q;
        err_cause_d  = err_cause_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    req_valid_d = 1'b0;
                    fetch_err_d = 1'b1;
                    err_cause_d = ERR_MISALIGN;
                    state_d     = S_ERR;
                end else if (req_valid_q && bus.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_RESP;
                end else begin
                    req_valid_d = 1'b1;
                end
            end

            S_RESP: begin
                cnt_d = cnt_at_limit ? cnt_q : cnt_q + CNT_W'(1);
                if (bus.pc_upd_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = bus.pc_upd;
                end
                // A response in the limit cycle still wins over the timeout
                if (bus.mem_resp_valid) begin
                    if (bus.mem_resp_err) begin
                        fetch_err_d = 1'b1;
                        err_cause_d = ERR_MEM;
                        state_d     = S_ERR;
                    end else begin
                        inst_d      = bus.mem_resp_data;
                        ifu_valid_d = 1'b1;
                        state_d     = S_SEND;
                    end
                end else if (cnt_at_limit) begin
                    fetch_err_d = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                    state_d     = S_ERR;
                end
            end

            S_SEND: begin
                if (bus.pc_upd_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = bus.pc_upd;
                end
                if (ifu_valid_q && bus.IDU_ready) begin
                    ifu_valid_d = 1'b0;
                    state_d     = S_WAITPC;
                end
            end

            S_WAITPC: begin
                // A live pulse is newer than anything parked in the pending register
                if (bus.pc_upd_valid) begin
                    pc_d         = bus.pc_upd;
                    pend_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else if (pend_valid_q) begin
                    pc_d         = pend_pc_q;
                    pend_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end

            S_ERR: begin
                fetch_err_d = 1'b1;
                ifu_valid_d = 1'b0;
                req_valid_d = 1'b0;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            ifu_valid_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
            err_cause_q  <= ERR_NONE;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            ifu_valid_q  <= ifu_valid_d;
            req_valid_q  <= req_valid_d;
            fetch_err_q  <= fetch_err_d;
            err_cause_q  <= err_cause_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = pc_q;
    assign bus.IFU_valid     = ifu_valid_q;
    assign bus.inst          = inst_q;
    assign bus.pc            = pc_q;
    assign bus.fetch_err     = fetch_err_q;
    assign bus.err_cause     = err_cause_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: the transmitting end of the IFU→IDU valid/ready handshake of the multi-cycle core.
- Holds the PC and issues one word read per instruction to the instruction memory port.
- Captures the returned word and presents it to the decode stage with IFU_valid until the decode stage accepts it (IDU_ready).
- Waits for the next-PC update from the execute/writeback side before fetching again. Non-pipelined: at most one instruction in flight.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- TIMEOUT, 255, max cycles waiting for a memory response before flagging an error; 8-bit counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- mem_req_valid  output  1  read request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  word address (= pc)
- mem_resp_valid  input  1  read data valid
- mem_resp_data  input  32  instruction word
- mem_resp_err  input  1  access fault, qualified by mem_resp_valid
- IFU_valid  output  1  inst/pc valid toward decode
- IDU_ready  input  1  decode stage can accept
- inst  output  32  fetched instruction
- pc  output  32  PC of inst
- pc_upd_valid  input  1  next PC available (one-cycle pulse)
- pc_upd  input  32  next PC value
- fetch_err  output  1  sticky fault flag
- err_cause  output  2  0 none, 1 misaligned PC, 2 memory error, 3 timeout

Behaviour:
- Reset (rst low, asynchronous): state=REQ, pc=RESET_PC, inst=0, IFU_valid=0, mem_req_valid=0, fetch_err=0, err_cause=0, timeout counter=0, pend_valid=0.
- All outputs are registered except mem_req_addr, which is combinational from pc.
- REQ:
  - If pc[1:0]!=0: go to ERR with err_cause=1; no request issued.
  - Otherwise drive mem_req_valid=1.
  - When mem_req_valid&mem_req_ready: drop mem_req_valid, clear the counter, go to RESP.
  - mem_req_valid and mem_req_addr stay stable until accepted.
  - First request is visible in the cycle after reset release.
- RESP:
  - Counter increments each cycle.
  - On mem_resp_valid & !mem_resp_err: latch inst=mem_resp_data, set IFU_valid=1 next cycle, go to SEND.
  - On mem_resp_valid & mem_resp_err: go to ERR, err_cause=2.
  - If the counter reaches TIMEOUT without mem_resp_valid: go to ERR, err_cause=3.
  - mem_resp_valid arriving in the same cycle the counter hits TIMEOUT is taken as a valid response.
- SEND:
  - IFU_valid=1; inst and pc are held stable.
  - On IFU_valid&IDU_ready (the handshake): IFU_valid=0 next cycle, go to WAITPC.
- WAITPC:
  - On pc_upd_valid: pc=pc_upd, go to REQ.
  - If the pending register is set on entry: use it the same cycle, go to REQ next cycle, clear pend_valid.
- Early update: a pc_upd_valid seen in RESP or SEND is stored in the pending register (pend_valid=1, pend_pc).
- Multiple pc_upd_valid pulses: a later pulse overwrites the pending value; last one wins.
- pc_upd_valid in REQ or ERR is ignored.
- ERR:
  - Terminal until reset. fetch_err=1; IFU_valid=0; mem_req_valid=0.
  - An outstanding mem_resp_valid is ignored.
- Mid-operation reset: any state returns to the reset values immediately; no handshake is completed.
- Arithmetic: pc is 32-bit with no increment inside the block; next PC always comes from pc_upd. The counter saturates at TIMEOUT.

Test Plan:
- Reset release, memory with req_ready=1 and a 1-cycle response of 32'h00000413 → req addr 32'h8000_0000 in cycle 1; IFU_valid=1 by cycle 3 with inst=32'h00000413; IDU_ready=1 → IFU_valid=0 next cycle.
- Backpressure: req_ready low 4 cycles and IDU_ready low 5 cycles → mem_req_addr, inst and pc stable throughout; exactly one request and one handshake.
- Early pc_upd=32'h8000_0010 pulsed during SEND → after the handshake, next request is issued to 32'h8000_0010 without waiting in WAITPC.
- pc_upd=32'h8000_0006 → no request issued, fetch_err=1, err_cause=1; later pc_upd pulses are ignored.
- Response withheld for TIMEOUT=255 cycles → fetch_err=1, err_cause=3; mem_resp_err=1 instead → err_cause=2.
- rst asserted in RESP with a response pending → IFU_valid and mem_req_valid are 0 immediately; after release, the request restarts at RESET_PC.
